// File: rtl/pe_wt_loader.sv
// Weight loader: assembles 3*3 or 5*5 kernels from a byte stream into PE weight words.
// Optional running byte checksum output when WT_LOAD_CKSUM_EN is defined.
package pe_wt_pkg;
    typedef struct packed {
        logic [8:0][7:0] a_9;
        logic [5:0][7:0] b_6;
        logic [5:0][7:0] c_6;
        logic [3:0][7:0] d_4;
    } PE_weight_t;

    typedef enum logic [2:0] {
        A_MODE = 3'd0,
        B_MODE = 3'd1,
        C_MODE = 3'd2,
        D_MODE = 3'd3,
        E_MODE = 3'd4
    } PE_weight_mode_t;
endpackage

module pe_wt_loader
    import pe_wt_pkg::*;
#(
    parameter int BIT_WIDTH = 8,
    parameter int NUM_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 kernel_mode,
    input  logic [NUM_WIDTH-1:0] num_kernel,
    input  logic [BIT_WIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output PE_weight_t           out_wt,
    output PE_weight_mode_t      out_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
`ifdef WT_LOAD_CKSUM_EN
    output logic [15:0]          cksum,
`endif
    output logic                 done
);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

    state_t                 state_q, state_d;
    logic [4:0]             byte_cnt_q, byte_cnt_d;
    logic [NUM_WIDTH-1:0]   kern_cnt_q, kern_cnt_d;
    logic [NUM_WIDTH-1:0]   num_q, num_d;
    logic                   mode_q, mode_d;
    PE_weight_t             out_wt_q, out_wt_d;
    PE_weight_mode_t        out_mode_q, out_mode_d;
    logic                   zero_done_q, zero_done_d;
    logic                   last_hs;
    logic [4:0]             last_byte;
`ifdef WT_LOAD_CKSUM_EN
    logic [15:0]            cksum_q, cksum_d;
`endif

    assign last_byte = mode_q ? 5'd24 : 5'd8;

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        kern_cnt_d  = kern_cnt_q;
        num_d       = num_q;
        mode_d      = mode_q;
        out_wt_d    = out_wt_q;
        out_mode_d  = out_mode_q;
        zero_done_d = 1'b0;
        last_hs     = 1'b0;
`ifdef WT_LOAD_CKSUM_EN
        cksum_d     = cksum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d     = kernel_mode;
                    num_d      = num_kernel;
                    byte_cnt_d = 5'd0;
                    kern_cnt_d = '0;
                    out_wt_d   = '0;
                    out_mode_d = kernel_mode ? A_MODE : E_MODE;
`ifdef WT_LOAD_CKSUM_EN
                    cksum_d    = 16'd0;
`endif
                    // An empty job never leaves IDLE; done follows one cycle later.
                    if (num_kernel == '0) zero_done_d = 1'b1;
                    else                  state_d     = LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    if (byte_cnt_q < 5'd9)
                        out_wt_d.a_9[byte_cnt_q[3:0]] = in_data;
                    else if (byte_cnt_q < 5'd15)
                        out_wt_d.b_6[3'(byte_cnt_q - 5'd9)] = in_data;
                    else if (byte_cnt_q < 5'd21)
                        out_wt_d.c_6[3'(byte_cnt_q - 5'd15)] = in_data;
                    else
                        out_wt_d.d_4[2'(byte_cnt_q - 5'd21)] = in_data;
`ifdef WT_LOAD_CKSUM_EN
                    cksum_d = cksum_q + 16'(in_data);
`endif
                    if (byte_cnt_q == last_byte) state_d = HOLD;
                    else                         byte_cnt_d = byte_cnt_q + 5'd1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    kern_cnt_d = kern_cnt_q + NUM_WIDTH'(1);
                    if (kern_cnt_d == num_q) begin
                        state_d = IDLE;
                        last_hs = 1'b1;
                    end else begin
                        state_d    = LOAD;
                        byte_cnt_d = 5'd0;
                        out_wt_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            byte_cnt_q  <= 5'd0;
            kern_cnt_q  <= '0;
            num_q       <= '0;
            mode_q      <= 1'b0;
            out_wt_q    <= '0;
            out_mode_q  <= A_MODE;
            zero_done_q <= 1'b0;
`ifdef WT_LOAD_CKSUM_EN
            cksum_q     <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            kern_cnt_q  <= kern_cnt_d;
            num_q       <= num_d;
            mode_q      <= mode_d;
            out_wt_q    <= out_wt_d;
            out_mode_q  <= out_mode_d;
            zero_done_q <= zero_done_d;
`ifdef WT_LOAD_CKSUM_EN
            cksum_q     <= cksum_d;
`endif
        end
    end

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign out_wt    = out_wt_q;
    assign out_mode  = out_mode_q;
    // Final handshake raises done in the same cycle; the empty-job pulse is registered.
    assign done      = zero_done_q | last_hs;
`ifdef WT_LOAD_CKSUM_EN
    assign cksum     = cksum_q;
`endif

endmodule

// File: tb/tb_pe_wt_loader.sv
// Directed self-checking bench for pe_wt_loader; checksum checks only when WT_LOAD_CKSUM_EN is defined.
module tb_pe_wt_loader;
    import pe_wt_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start, kernel_mode, in_valid, out_ready;
    logic [7:0]      num_kernel, in_data;
    logic            in_ready, out_valid, busy, done;
    PE_weight_t      out_wt;
    PE_weight_mode_t out_mode;
`ifdef WT_LOAD_CKSUM_EN
    logic [15:0]     cksum;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int hs_cnt;
    PE_weight_t exp_wt;

    always #5 clk = ~clk;

    pe_wt_loader #(.BIT_WIDTH(8), .NUM_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .kernel_mode(kernel_mode),
        .num_kernel(num_kernel), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_wt(out_wt), .out_mode(out_mode),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
`ifdef WT_LOAD_CKSUM_EN
        .cksum(cksum),
`endif
        .done(done)
    );

    task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic PE_weight_t exp_kernel(input int first, input bit five);
        PE_weight_t e = '0;
        for (int k = 0; k < 9; k++) e.a_9[k] = 8'(first + k);
        if (five) begin
            for (int k = 0; k < 6; k++) begin
                e.b_6[k] = 8'(first + 9 + k);
                e.c_6[k] = 8'(first + 15 + k);
            end
            for (int k = 0; k < 4; k++) e.d_4[k] = 8'(first + 21 + k);
        end
        return e;
    endfunction

    // Accepted start; mode/count are then scrambled to show they are latched.
    task automatic do_start(input bit mode, input int num);
        start = 1'b1; kernel_mode = mode; num_kernel = 8'(num);
        tick();
        start = 1'b0; kernel_mode = ~mode; num_kernel = 8'hEE;
    endtask

    task automatic stream(input int first, input int n, input bit gaps, input bit poke);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                in_valid = 1'b0; in_data = 8'h5A;
                tick();
            end
            in_valid = 1'b1; in_data = 8'(first + i);
            start = (poke && i == n / 2);
            chk("in_ready_load", in_ready, 1'b1);
            if (i == n - 1) chk("out_valid_before_last", out_valid, 1'b0);
            tick();
            start = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; kernel_mode = 1'b0; num_kernel = 8'd0;
        in_data = 8'd0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        chk("rst_out_wt", out_wt, 200'd0);
        chk("rst_out_mode", out_mode, 3'd0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        rst_n = 1'b1;
        tick();

        // 3*3, one kernel, bytes 1..9 back-to-back
        out_ready = 1'b1;
        do_start(1'b0, 1);
        chk("t1_busy", busy, 1'b1);
        stream(1, 9, 1'b0, 1'b0);
        chk("t1_out_valid", out_valid, 1'b1);
        chk("t1_out_wt", out_wt, exp_kernel(1, 1'b0));
        chk("t1_a9_8", out_wt.a_9[8], 8'd9);
        chk("t1_mode", out_mode, E_MODE);
        chk("t1_in_ready_hold", in_ready, 1'b0);
        chk("t1_done", done, 1'b1);
`ifdef WT_LOAD_CKSUM_EN
        chk("t1_cksum", cksum, 16'd45);
`endif
        tick();
        chk("t1_done_clear", done, 1'b0);
        chk("t1_idle", busy, 1'b0);
        chk("t1_out_valid_clear", out_valid, 1'b0);

        // 5*5, two kernels, bytes 0..49, stalled output on kernel 0
        out_ready = 1'b0;
        hs_cnt = 0;
        do_start(1'b1, 2);
        stream(0, 25, 1'b0, 1'b0);
        exp_wt = exp_kernel(0, 1'b1);
        chk("t2_k0_valid", out_valid, 1'b1);
        chk("t2_k0_wt", out_wt, exp_wt);
        chk("t2_k0_d4_3", out_wt.d_4[3], 8'd24);
        chk("t2_k0_mode", out_mode, A_MODE);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_data = 8'hAA;
            tick();
            chk("t3_hold_wt", out_wt, exp_wt);
            chk("t3_hold_in_ready", in_ready, 1'b0);
            chk("t3_hold_valid", out_valid, 1'b1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("t2_k0_done", done, 1'b0);
        if (out_valid && out_ready) hs_cnt++;
        tick();
        chk("t2_reload_in_ready", in_ready, 1'b1);
        chk("t2_reload_valid", out_valid, 1'b0);
        chk("t2_reload_clear", out_wt, 200'd0);
        stream(25, 25, 1'b0, 1'b1);
        chk("t2_k1_wt", out_wt, exp_kernel(25, 1'b1));
        chk("t2_k1_a9_0", out_wt.a_9[0], 8'd25);
        chk("t2_k1_d4_3", out_wt.d_4[3], 8'd49);
        chk("t2_k1_mode", out_mode, A_MODE);
        chk("t2_k1_done", done, 1'b1);
        if (out_valid && out_ready) hs_cnt++;
        tick();
        for (int c = 0; c < 2; c++) begin
            if (out_valid && out_ready) hs_cnt++;
            tick();
        end
        chk("t2_hs_count", hs_cnt, 2);
        chk("t2_idle", busy, 1'b0);
        chk("t2_done_clear", done, 1'b0);

        // 3*3 with bubbles and a stray start mid-job
        do_start(1'b0, 1);
        stream(1, 9, 1'b1, 1'b1);
        chk("t4_wt", out_wt, exp_kernel(1, 1'b0));
        chk("t4_mode", out_mode, E_MODE);
        chk("t4_done", done, 1'b1);
        tick();
        chk("t4_idle", busy, 1'b0);
        chk("t4_no_restart", in_ready, 1'b0);

        // empty job
        do_start(1'b0, 0);
        chk("t5_done", done, 1'b1);
        chk("t5_busy", busy, 1'b0);
        chk("t5_out_valid", out_valid, 1'b0);
        tick();
        chk("t5_done_clear", done, 1'b0);

        // reset after byte 12 of a 5*5 kernel
        do_start(1'b1, 1);
        stream(100, 12, 1'b0, 1'b0);
        chk("t6_partial", out_wt.a_9[8], 8'd108);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_wt", out_wt, 200'd0);
        chk("t6_rst_mode", out_mode, 3'd0);
        chk("t6_rst_in_ready", in_ready, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_done", done, 1'b0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t6_no_done", done, 1'b0);
            chk("t6_stay_idle", busy, 1'b0);
        end
        do_start(1'b0, 1);
        stream(1, 9, 1'b0, 1'b0);
        chk("t6_fresh_wt", out_wt, exp_kernel(1, 1'b0));
        tick();

`ifdef WT_LOAD_CKSUM_EN
        do_start(1'b1, 12);
        for (int k = 0; k < 12; k++) begin
            for (int b = 0; b < 25; b++) begin
                in_valid = 1'b1; in_data = 8'hFF;
                tick();
            end
            in_valid = 1'b0;
            tick();
        end
        chk("t7_cksum", cksum, 16'h2AD4);
        chk("t7_idle", busy, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pe_wt_loader.md
PE_WT_LOADER -- requirements
Module: pe_wt_loader

Interface
REQ-001 Parameter BIT_WIDTH, default 8: weight element width in bits; only 8 is supported.
REQ-002 Parameter NUM_WIDTH, default 8: width of the kernel-count field; the supported count is at most 250.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port start, input, 1: one-cycle load request; it is acted on only in IDLE.
REQ-006 Port kernel_mode, input, 1: selects kernel size, 0 = 3*3, 1 = 5*5; sampled when start is accepted.
REQ-007 Port num_kernel, input, NUM_WIDTH: number of kernels to load; sampled when start is accepted.
REQ-008 Port in_data, input, BIT_WIDTH: incoming weight byte from the DDR stream.
REQ-009 Port in_valid, input, 1: in_data is valid.
REQ-010 Port in_ready, output, 1: the loader accepts in_data this cycle.
REQ-011 Port out_wt, output, PE_weight_t (200 bits): the assembled kernel.
REQ-012 Port out_mode, output, PE_weight_mode_t: the weight mode of out_wt.
REQ-013 Port out_valid, output, 1: out_wt and out_mode are valid.
REQ-014 Port out_ready, input, 1: the PE accepts out_wt this cycle.
REQ-015 Port busy, output, 1: the FSM is not in IDLE.
REQ-016 Port done, output, 1: one-cycle pulse when the whole job completes.

Function
REQ-017 The FSM SHALL have exactly three states, IDLE, LOAD and HOLD.
REQ-018 In IDLE with start=1 the block SHALL latch mode and count, clear the byte and kernel counters, and go to LOAD; if num_kernel=0 it SHALL stay in IDLE and pulse done on the next cycle.
REQ-019 in_ready SHALL equal 1 only in LOAD; a byte is accepted when in_valid and in_ready are both 1.
REQ-020 A 5*5 kernel SHALL be 25 row-major bytes b0..b24 mapped as: b0..b8 to A_9[0..8], b9..b14 to B_6[0..5], b15..b20 to C_6[0..5], b21..b24 to D_4[0..3]; out_mode SHALL be A_MODE.
REQ-021 A 3*3 kernel SHALL be 9 bytes mapped to A_9[0..8], with B_6, C_6 and D_4 forced to zero; out_mode SHALL be E_MODE.
REQ-022 When the last byte of a kernel is accepted, the FSM SHALL go to HOLD, and out_valid SHALL be 1 on the next cycle (latency 1).
REQ-023 In HOLD, out_wt and out_mode SHALL stay stable until out_valid and out_ready are both 1.
REQ-024 On that output handshake the kernel counter SHALL increment; if it reaches the latched count, the FSM SHALL go to IDLE and pulse done in the same cycle; otherwise it SHALL return to LOAD with the byte counter at 0.
REQ-025 start SHALL be ignored while busy=1.
REQ-026 Changes to kernel_mode or num_kernel mid-job SHALL have no effect.
REQ-027 Bubbles on in_valid SHALL only stall the load; the byte count SHALL never skip or repeat.
REQ-028 out_wt SHALL be cleared to zero at the start of every kernel.

Reset
REQ-029 When rst_n=0, asynchronously: state SHALL be IDLE; all counters, out_wt and out_mode SHALL be 0; in_ready, out_valid, busy and done SHALL be 0.
REQ-030 A reset mid-job SHALL abandon the job with no done pulse; a fresh start is required afterwards.

Configuration
REQ-031 With WT_LOAD_CKSUM_EN defined, there SHALL be an extra output port cksum, 16 bits, holding the unsigned wrap-around sum of all bytes accepted since the last accepted start; it SHALL be cleared by reset and by an accepted start.
REQ-032 Without WT_LOAD_CKSUM_EN, the cksum port and its logic SHALL be absent, with no other change in behaviour.

Verification
REQ-033 Reset, then start with kernel_mode=0, num_kernel=1, and bytes 1..9 streamed back-to-back -> A_9[k]=k+1, other fields 0, out_mode=E_MODE; out_valid rises 1 cycle after the last byte; with out_ready=1, done pulses on that cycle.
REQ-034 kernel_mode=1, num_kernel=2, bytes 0..49 -> kernel 0 gives D_4[3]=24; kernel 1 gives A_9[0]=25 and D_4[3]=49; out_mode=A_MODE; exactly 2 output handshakes, then done.
REQ-035 out_ready held at 0 for 5 cycles in HOLD -> out_wt stable, in_ready=0, no bytes consumed.
REQ-036 in_valid toggling every other cycle -> same result as back-to-back input; a second start while busy is ignored.
REQ-037 num_kernel=0 -> done pulses on the next cycle, no out_valid; rst_n pulsed low after byte 12 of a 5*5 kernel -> all outputs 0 and no done.
REQ-038 With WT_LOAD_CKSUM_EN and bytes 1..9 -> cksum=45; with 300 bytes of 0xFF across twelve 5*5 kernels -> cksum=0x2AD4.
